shared_resource_arb_n: RTL and testbench
========================================

// Module: shared_resource_arb_n
// PURPOSE
//  Parametrised N-channel front end for one shared combinational resource; generalises the two-channel wrapper.
//  Each channel has its own input FIFO (with empty-bypass), its own registered output stage, and its own flush/stall handshake.
//  A round-robin arbiter grants at most one channel per cycle to the resource.
//  Sits between N independent pipeline stages and a single shared datapath unit.
// PARAMETERS
//  NUM_CH     4   number of channels, >=2
//  DATA_W    32   data width per channel and of the resource
//  BUF_DEPTH  2   entries per channel FIFO, >=1, any integer (not restricted to a power of two)
// PORTS
//  clk          in   1              clock, rising edge
//  reset        in   1              asynchronous, active-high
//  in_valid     in   NUM_CH         per-channel upstream valid
//  in_data      in   NUM_CH*DATA_W  channel i occupies [i*DATA_W +: DATA_W]
//  out_stall    out  NUM_CH         per-channel backpressure to upstream (FIFO full)
//  in_stall     in   NUM_CH         per-channel downstream stall
//  in_flush     in   NUM_CH         per-channel synchronous flush
//  out_valid    out  NUM_CH         per-channel registered result valid
//  out_data     out  NUM_CH*DATA_W  per-channel registered result
//  out_flush    out  NUM_CH         per-channel registered flush echo
//  res_req_data out  DATA_W         operand to the shared resource; 0 when no grant
//  res_req_ch   out  clog2(NUM_CH)  granted channel index; 0 when no grant
//  res_req_vld  out  1              a grant is active this cycle
//  res_rsp_data in   DATA_W         resource result, combinational, same cycle
// BEHAVIOUR
//  Reset: all FIFOs empty; out_valid=0, out_data=0, out_flush=0, out_stall=0; rr_ptr=0.
//  Upstream handshake per channel i:
//   - accept_i = in_valid[i] & !out_stall[i] & !in_flush[i].
//   - out_stall[i] = fifo_full[i]. While stalled, upstream holds its data.
//  Head operand: FIFO head if FIFO non-empty, else in_data[i] (bypass). has_req_i = !empty_i | accept_i.
//  Output ready: ordy_i = !out_valid[i] | !in_stall[i].
//  Eligibility: elig_i = has_req_i & ordy_i & !in_flush[i].
//  Arbiter:
//   - Grant the first eligible channel searching from rr_ptr upward, with wrap-around.
//   - On a grant to channel g, rr_ptr <= (g+1) mod NUM_CH. With no grant, rr_ptr holds.
//  fire_i = grant_i.
//  Enqueue/dequeue:
//   - If FIFO is empty and fire_i and accept_i, the data bypasses the FIFO (no enqueue).
//   - Else if accept_i, enqueue.
//   - If FIFO is non-empty and fire_i, dequeue.
//   - Simultaneous enqueue and dequeue keeps the count unchanged and is legal when the FIFO is full.
//  Output stage:
//   - On fire_i: out_valid[i]<=1 and out_data[i]<=res_rsp_data.
//   - Else if !in_stall[i]: out_valid[i]<=0.
//   - Otherwise hold. out_data holds when not fired.
//  Latency: an accepted beat into an empty, ungranted-contention channel appears on out_valid/out_data 1 cycle later.
//  Throughput: one beat per cycle aggregate; a single active channel sustains 1 beat/cycle.
//  Flush on channel i:
//   - FIFO cleared and out_valid[i]<=0 at the next edge.
//   - out_flush[i]<=1 for that cycle (registered echo of in_flush).
//   - Input that cycle is dropped; no grant to i.
//   - Other channels are unaffected; rr_ptr is unaffected unless another channel is granted.
//  Reset asserted mid-operation clears all state immediately; in-flight beats are lost.
//  No beat is duplicated or reordered within a channel.
// CONFIGURATION
//  SHARED_RES_FIXED_PRIO_EN defined:
//   - The arbiter uses fixed priority, lowest index wins.
//   - rr_ptr is removed (constant 0).
//  Not defined: round-robin as above.
//  Ports and all other behaviour are identical in both builds.
// TESTING (NUM_CH=4, DATA_W=32, BUF_DEPTH=2; bench model res_rsp=res_req+1)
//  1. Reset, then in_valid[0]=1 with data 0x10 for one cycle
//     -> next cycle out_valid[0]=1, out_data[0]=0x11, res_req_ch=0.
//  2. All 4 channels valid every cycle
//     -> grants 0,1,2,3,0,... one per cycle.
//     -> out_stall[i] asserts once each FIFO reaches 2 entries.
//     -> per-channel output order is preserved.
//  3. in_stall[1]=1 with out_valid[1]=1 for 3 cycles
//     -> channel 1 is never granted and out_data[1] holds.
//     -> other channels keep being served.
//  4. Channel 2 FIFO full (0xA,0xB) plus in_flush[2]
//     -> next cycle FIFO empty, out_valid[2]=0, out_flush[2]=1, out_stall[2]=0.
//     -> 0xA and 0xB never appear on out_data[2].
//  5. Only channel 3 requests, with rr_ptr=0 -> immediate grant to 3, then rr_ptr=0.
//     With SHARED_RES_FIXED_PRIO_EN and channels 0 and 3 requesting continuously -> channel 3 never granted.
//  6. Assert reset while FIFOs are half full -> all outputs 0 immediately; no stale beats after release.

Source files
------------

// File: rtl/shared_resource_arb_n.sv
// shared_resource_arb_n: N-channel front end that shares one combinational
// datapath unit. Each channel has a small input FIFO with empty-bypass, a
// registered output stage and a flush/stall handshake. One channel per cycle is
// granted to the shared unit.
// Build option: define SHARED_RES_FIXED_PRIO_EN to replace the round-robin
// arbiter with fixed priority (lowest channel index wins, no rr pointer).
module shared_resource_arb_n #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          in_valid,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    output logic [NUM_CH-1:0]          out_stall,
    input  logic [NUM_CH-1:0]          in_stall,
    input  logic [NUM_CH-1:0]          in_flush,
    output logic [NUM_CH-1:0]          out_valid,
    output logic [NUM_CH*DATA_W-1:0]   out_data,
    output logic [NUM_CH-1:0]          out_flush,
    output logic [DATA_W-1:0]          res_req_data,
    output logic [$clog2(NUM_CH)-1:0]  res_req_ch,
    output logic                       res_req_vld,
    input  logic [DATA_W-1:0]          res_rsp_data
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int IDX_W = CH_W + 1;
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    // FIFO pointers wrap at BUF_DEPTH, which need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] accept;
    logic [NUM_CH-1:0] has_req;
    logic [NUM_CH-1:0] ordy;
    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] grant;
    logic [DATA_W-1:0] head_data [NUM_CH];
    logic              gnt_any;
    logic [CH_W-1:0]   gnt_idx;
    logic [NUM_CH-1:0] out_flush_q, out_flush_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0]  count_q, count_d;
            logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
            logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
            logic [DATA_W-1:0] mem_q [BUF_DEPTH];
            logic              out_valid_q, out_valid_d;
            logic [DATA_W-1:0] out_data_q, out_data_d;
            logic              enq;
            logic              deq;

            assign full[gi]      = (count_q == CNT_W'(BUF_DEPTH));
            assign empty[gi]     = (count_q == '0);
            assign accept[gi]    = in_valid[gi] & ~full[gi] & ~in_flush[gi];
            // Empty FIFO: the live input is the operand (bypass)
            assign head_data[gi] = empty[gi] ? in_data[gi*DATA_W +: DATA_W] : mem_q[rd_ptr_q];
            assign has_req[gi]   = ~empty[gi] | accept[gi];
            assign ordy[gi]      = ~out_valid_q | ~in_stall[gi];
            assign elig[gi]      = has_req[gi] & ordy[gi] & ~in_flush[gi];
            // A beat granted straight from the input never enters the FIFO
            assign enq           = accept[gi] & ~(empty[gi] & grant[gi]);
            assign deq           = ~empty[gi] & grant[gi];

            // Next state of the channel FIFO and its output stage
            always_comb begin
                count_d     = count_q;
                rd_ptr_d    = rd_ptr_q;
                wr_ptr_d    = wr_ptr_q;
                out_valid_d = out_valid_q;
                out_data_d  = out_data_q;
                if (in_flush[gi]) begin
                    count_d     = '0;
                    rd_ptr_d    = '0;
                    wr_ptr_d    = '0;
                    out_valid_d = 1'b0;
                end else begin
                    if (enq) wr_ptr_d = ptr_inc(wr_ptr_q);
                    if (deq) rd_ptr_d = ptr_inc(rd_ptr_q);
                    if (enq && !deq)
                        count_d = count_q + CNT_W'(1);
                    else if (deq && !enq)
                        count_d = count_q - CNT_W'(1);
                    if (grant[gi]) begin
                        out_valid_d = 1'b1;
                        out_data_d  = res_rsp_data;
                    end else if (!in_stall[gi]) begin
                        out_valid_d = 1'b0;
                    end
                end
            end

            // Channel control state, cleared immediately by reset
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    count_q     <= '0;
                    rd_ptr_q    <= '0;
                    wr_ptr_q    <= '0;
                    out_valid_q <= 1'b0;
                    out_data_q  <= '0;
                end else begin
                    count_q     <= count_d;
                    rd_ptr_q    <= rd_ptr_d;
                    wr_ptr_q    <= wr_ptr_d;
                    out_valid_q <= out_valid_d;
                    out_data_q  <= out_data_d;
                end
            end

            // FIFO storage; contents are don't-care while count is zero
            always_ff @(posedge clk) begin
                if (enq) mem_q[wr_ptr_q] <= in_data[gi*DATA_W +: DATA_W];
            end

            assign out_valid[gi]                = out_valid_q;
            assign out_data[gi*DATA_W +: DATA_W] = out_data_q;
        end
    endgenerate

    assign out_stall = full;

`ifdef SHARED_RES_FIXED_PRIO_EN
    // Fixed priority: lowest eligible index wins
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (elig[k]) begin
                gnt_any = 1'b1;
                gnt_idx = CH_W'(k);
            end
        end
    end
`else
    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;

    // Round-robin: first eligible channel at or above rr_ptr, wrapping around
    always_comb begin
        logic [IDX_W-1:0] idx_w;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx_w   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx_w = {1'b0, rr_ptr_q} + IDX_W'(k);
            if (idx_w >= IDX_W'(NUM_CH)) idx_w = idx_w - IDX_W'(NUM_CH);
            if (!gnt_any && elig[idx_w[CH_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = idx_w[CH_W-1:0];
            end
        end
    end

    // Pointer moves just past the granted channel; holds when idle
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_any)
            rr_ptr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
    end

    // Round-robin pointer register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end
`endif

    // One-hot grant decode
    always_comb begin
        grant = '0;
        if (gnt_any) grant[gnt_idx] = 1'b1;
    end

    // Flush echo is a plain registered copy of in_flush
    always_comb begin
        out_flush_d = in_flush;
    end

    // Flush echo register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) out_flush_q <= '0;
        else       out_flush_q <= out_flush_d;
    end

    assign out_flush    = out_flush_q;
    assign res_req_vld  = gnt_any;
    assign res_req_ch   = gnt_any ? gnt_idx : '0;
    assign res_req_data = gnt_any ? head_data[gnt_idx] : '0;

endmodule

// File: tb/tb_shared_resource_arb_n.sv
// Directed bench for shared_resource_arb_n (NUM_CH=4, DATA_W=32, BUF_DEPTH=2).
// The shared resource is modelled as res_rsp = res_req + 1. Expected output
// beats are queued per channel when the input handshake completes; a negedge
// monitor pops and compares whenever a channel's output beat is taken.
module tb_shared_resource_arb_n;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_CH-1:0]         in_valid;
    logic [NUM_CH*DATA_W-1:0]  in_data;
    logic [NUM_CH-1:0]         out_stall;
    logic [NUM_CH-1:0]         in_stall;
    logic [NUM_CH-1:0]         in_flush;
    logic [NUM_CH-1:0]         out_valid;
    logic [NUM_CH*DATA_W-1:0]  out_data;
    logic [NUM_CH-1:0]         out_flush;
    logic [DATA_W-1:0]         res_req_data;
    logic [1:0]                res_req_ch;
    logic                      res_req_vld;
    logic [DATA_W-1:0]         res_rsp_data;

    logic [DATA_W-1:0] tb_data [NUM_CH];
    logic [DATA_W-1:0] exp_q [NUM_CH][$];
    logic [NUM_CH-1:0] acc;
    logic [DATA_W-1:0] mon_exp;
    int vectors    = 0;
    int miscompares = 0;

    shared_resource_arb_n #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .BUF_DEPTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .out_stall    (out_stall),
        .in_stall     (in_stall),
        .in_flush     (in_flush),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_flush    (out_flush),
        .res_req_data (res_req_data),
        .res_req_ch   (res_req_ch),
        .res_req_vld  (res_req_vld),
        .res_rsp_data (res_rsp_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        in_data = '0;
        for (int c = 0; c < NUM_CH; c++) in_data[c*DATA_W +: DATA_W] = tb_data[c];
    end

    assign res_rsp_data = res_req_data + 32'd1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Output beat is taken when out_valid is high and downstream is not stalling
    always @(negedge clk) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (out_valid[c] && !in_stall[c]) begin
                    vectors++;
                    if (exp_q[c].size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_beat ch%0d: got 0x%0h, expected no beat",
                                 c, out_data[c*DATA_W +: DATA_W]);
                    end else begin
                        mon_exp = exp_q[c].pop_front();
                        if (out_data[c*DATA_W +: DATA_W] !== mon_exp) begin
                            miscompares++;
                            $display("FAIL beat_data ch%0d: got 0x%0h, expected 0x%0h",
                                     c, out_data[c*DATA_W +: DATA_W], mon_exp);
                        end else begin
                            $display("ch%0d beat 0x%0h ok", c, mon_exp);
                        end
                    end
                end
                if (in_flush[c]) exp_q[c].delete();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let inputs settle, then record beats the DUT accepts at the coming edge
    task automatic settle();
        #1;
        acc = in_valid & ~out_stall & ~in_flush;
        for (int c = 0; c < NUM_CH; c++)
            if (acc[c]) exp_q[c].push_back(tb_data[c] + 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = '0;
        for (int i = 0; i < n; i++) begin
            settle();
            tick();
        end
    endtask

    task automatic do_reset();
        in_valid = '0;
        in_stall = '0;
        in_flush = '0;
        reset    = 1'b1;
        for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    int n_beat [NUM_CH];
    logic [1:0] exp_g2 [8];
    logic [1:0] exp_g3 [3];
    logic [1:0] exp_g5 [6];
    logic [3:0] exp_stall2;

    initial begin
`ifdef SHARED_RES_FIXED_PRIO_EN
        for (int k = 0; k < 8; k++) exp_g2[k] = 2'd0;
        for (int k = 0; k < 3; k++) exp_g3[k] = 2'd0;
        for (int k = 0; k < 6; k++) exp_g5[k] = 2'd0;
        exp_stall2 = 4'b1110;
`else
        for (int k = 0; k < 8; k++) exp_g2[k] = 2'(k % 4);
        exp_g3[0] = 2'd2; exp_g3[1] = 2'd0; exp_g3[2] = 2'd2;
        for (int k = 0; k < 6; k++) exp_g5[k] = (k % 2 == 0) ? 2'd0 : 2'd3;
        exp_stall2 = 4'b1100;
`endif
        for (int c = 0; c < NUM_CH; c++) tb_data[c] = '0;
        in_valid = '0; in_stall = '0; in_flush = '0;
        reset = 1'b1;
        tick();
        tick();
        // reset state
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data0", out_data[31:0], 32'h0);
        check("rst_out_stall", 32'(out_stall), 32'h0);
        check("rst_out_flush", 32'(out_flush), 32'h0);
        check("rst_req_vld",   32'(res_req_vld), 32'h0);
        check("rst_req_data",  res_req_data, 32'h0);
        reset = 1'b0;

        // single beat through channel 0: one cycle latency
        tb_data[0] = 32'h10; in_valid = 4'b0001;
        settle();
        check("t1_req_vld",  32'(res_req_vld), 32'h1);
        check("t1_req_ch",   32'(res_req_ch), 32'h0);
        check("t1_req_data", res_req_data, 32'h10);
        tick();
        in_valid = '0;
        check("t1_out_valid0", 32'(out_valid[0]), 32'h1);
        check("t1_out_data0",  out_data[31:0], 32'h11);
        idle(3);

        // all channels valid every cycle
        do_reset();
        for (int c = 0; c < NUM_CH; c++) n_beat[c] = 0;
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < NUM_CH; c++) tb_data[c] = 32'h100 * (c + 1) + 32'(n_beat[c]);
            in_valid = 4'b1111;
            settle();
            check($sformatf("t2_req_ch_c%0d", k), 32'(res_req_ch), 32'(exp_g2[k]));
            check($sformatf("t2_req_vld_c%0d", k), 32'(res_req_vld), 32'h1);
            if (k == 0) check("t2_stall_c0", 32'(out_stall), 32'h0);
            if (k == 2) check("t2_stall_c2", 32'(out_stall), 32'(exp_stall2));
            tick();
            for (int c = 0; c < NUM_CH; c++) if (acc[c]) n_beat[c]++;
        end
        idle(12);

        // downstream stall on channel 1 with a held result
        do_reset();
        tb_data[1] = 32'h20; in_valid = 4'b0010;
        settle();
        check("t3_first_ch", 32'(res_req_ch), 32'h1);
        tick();
        in_stall = 4'b0010;
        for (int s = 0; s < 3; s++) begin
            tb_data[0] = 32'h40 + 32'(s);
            tb_data[1] = 32'h30;
            tb_data[2] = 32'h50 + 32'(s);
            in_valid = (s == 0) ? 4'b0111 : 4'b0101;
            settle();
            check($sformatf("t3_out_valid1_s%0d", s), 32'(out_valid[1]), 32'h1);
            check($sformatf("t3_out_data1_s%0d", s), out_data[63:32], 32'h21);
            check($sformatf("t3_req_ch_s%0d", s), 32'(res_req_ch), 32'(exp_g3[s]));
            check($sformatf("t3_req_vld_s%0d", s), 32'(res_req_vld), 32'h1);
            tick();
        end
        in_valid = '0;
        in_stall = '0;
        idle(10);

        // flush a full channel 2
        do_reset();
        tb_data[2] = 32'h5; in_valid = 4'b0100;
        settle();
        tick();
        in_stall = 4'b0100;
        tb_data[2] = 32'hA;
        settle();
        check("t4_no_grant_stalled", 32'(res_req_vld), 32'h0);
        tick();
        tb_data[2] = 32'hB;
        settle();
        tick();
        in_valid = '0;
        check("t4_full_stall", 32'(out_stall[2]), 32'h1);
        in_flush = 4'b0100; in_valid = 4'b0100; tb_data[2] = 32'hEE;
        settle();
        check("t4_no_grant_flush", 32'(res_req_vld), 32'h0);
        tick();
        in_flush = '0; in_valid = '0;
        check("t4_out_valid2", 32'(out_valid[2]), 32'h0);
        check("t4_out_flush2", 32'(out_flush[2]), 32'h1);
        check("t4_out_stall2", 32'(out_stall[2]), 32'h0);
        in_stall = '0;
        tick();
        check("t4_flush_echo_off", 32'(out_flush[2]), 32'h0);
        tb_data[2] = 32'h70; in_valid = 4'b0100;
        settle();
        tick();
        idle(5);

        // lone request from channel 3, then pointer back at 0
        do_reset();
        tb_data[3] = 32'h33; in_valid = 4'b1000;
        settle();
        check("t5_lone_ch3", 32'(res_req_ch), 32'h3);
        check("t5_lone_vld", 32'(res_req_vld), 32'h1);
        tick();
        tb_data[0] = 32'h60; tb_data[1] = 32'h61; in_valid = 4'b0011;
        settle();
        check("t5_ptr_wrapped", 32'(res_req_ch), 32'h0);
        tick();
        idle(5);

        // channels 0 and 3 requesting continuously
        do_reset();
        n_beat[0] = 0; n_beat[3] = 0;
        for (int k = 0; k < 6; k++) begin
            tb_data[0] = 32'h200 + 32'(n_beat[0]);
            tb_data[3] = 32'h300 + 32'(n_beat[3]);
            in_valid = 4'b1001;
            settle();
            check($sformatf("t5_req_ch_c%0d", k), 32'(res_req_ch), 32'(exp_g5[k]));
            tick();
            if (acc[0]) n_beat[0]++;
            if (acc[3]) n_beat[3]++;
        end
        idle(12);
        for (int c = 0; c < NUM_CH; c++)
            check($sformatf("t5_drained_ch%0d", c), 32'(exp_q[c].size()), 32'h0);

        // reset in the middle of traffic
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < NUM_CH; c++) tb_data[c] = 32'h400 + 32'h10 * c + 32'(k);
            in_valid = 4'b1111;
            settle();
            tick();
        end
        in_valid = '0;
        reset = 1'b1;
        for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
        #1;
        check("t6_out_valid", 32'(out_valid), 32'h0);
        check("t6_out_stall", 32'(out_stall), 32'h0);
        check("t6_out_flush", 32'(out_flush), 32'h0);
        check("t6_out_data0", out_data[31:0], 32'h0);
        check("t6_req_vld",   32'(res_req_vld), 32'h0);
        tick();
        reset = 1'b0;
        idle(6);
        check("t6_no_stale", 32'(out_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
